// File: rtl/ifns_pkg.sv
// Shared constants, state encoding and forbidden-transition check for the
// 24-bit IFNS codeword to 17-bit data decoder.
package ifns_pkg;

  localparam int CW     = 24;
  localparam int DW     = 17;
  localparam int AW     = 18;
  localparam int MAXVAL = 131071;

  // Weight of codeword bit k-1 (d_k): F(k) for k = 1..23, then 75025 for d24.
  localparam logic [AW-1:0] FIB_W [0:CW-1] = '{
    18'd1,     18'd1,     18'd2,     18'd3,     18'd5,     18'd8,
    18'd13,    18'd21,    18'd34,    18'd55,    18'd89,    18'd144,
    18'd233,   18'd377,   18'd610,   18'd987,   18'd1597,  18'd2584,
    18'd4181,  18'd6765,  18'd10946, 18'd17711, 18'd28657, 18'd75025
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } ifns_state_t;

  // A pair of adjacent wires that both toggle into opposite values (01<->10).
  function automatic logic ft_check(input logic [CW-1:0] prev, input logic [CW-1:0] cur);
    logic ft;
    ft = 1'b0;
    for (int i = 0; i < CW - 1; i++) begin
      ft = ft | ((prev[i] ^ cur[i]) & (prev[i+1] ^ cur[i+1]) & (cur[i] ^ cur[i+1]));
    end
    return ft;
  endfunction

endpackage

// File: rtl/ifns_chunk_sum.sv
// Combinational weighted sum of one G-bit slice of the codeword, the slice
// being selected by the current accumulation step.
module ifns_chunk_sum
  import ifns_pkg::*;
#(
  parameter int G     = 6,
  parameter int STEPW = 2
) (
  input  logic [CW-1:0]    cw,
  input  logic [STEPW-1:0] step,
  output logic [AW-1:0]    sum
);

  logic [4:0]    base;
  logic [AW-1:0] term [G];

  assign base = 5'(step) * 5'(G);

  generate
    for (genvar gi = 0; gi < G; gi++) begin : g_term
      logic [4:0] idx;
      assign idx      = base + 5'(gi);
      assign term[gi] = cw[idx] ? FIB_W[idx] : '0;
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int j = 0; j < G; j++) begin
      sum = sum + term[j];
    end
  end

endmodule

// File: rtl/ifns_decoder_24to17_seq.sv
// Multi-cycle IFNS decoder: accepts a 24-bit codeword, accumulates its
// Fibonacci-weighted value G bits per cycle and flags range/transition errors.
module ifns_decoder_24to17_seq
  import ifns_pkg::*;
#(
  parameter int G = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [23:0]   in_cw,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [16:0]   out_data,
  output logic          out_range_err,
  output logic          out_ft_err
);

  localparam int NSTEP = CW / G;
  localparam int STEPW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [STEPW-1:0] LAST_STEP = STEPW'(NSTEP - 1);

  ifns_state_t      state_q, state_d;
  logic [CW-1:0]    cw_q, cw_d;
  logic [CW-1:0]    prev_q, prev_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [STEPW-1:0] step_q, step_d;
  logic             ft_q, ft_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_range_q, out_range_d;
  logic             out_ft_q, out_ft_d;

  logic [AW-1:0]    chunk_sum;
  logic [AW-1:0]    acc_sum;

  ifns_chunk_sum #(
    .G     (G),
    .STEPW (STEPW)
  ) u_chunk_sum (
    .cw   (cw_q),
    .step (step_q),
    .sum  (chunk_sum)
  );

  // 18 bits hold the largest possible sum (150049), so this never wraps.
  assign acc_sum = acc_q + chunk_sum;

  always_comb begin
    state_d     = state_q;
    cw_d        = cw_q;
    prev_d      = prev_q;
    acc_d       = acc_q;
    step_d      = step_q;
    ft_d        = ft_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_range_d = out_range_q;
    out_ft_d    = out_ft_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cw_d    = in_cw;
          prev_d  = in_cw;
          ft_d    = ft_check(prev_q, in_cw);
          acc_d   = '0;
          step_d  = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d  = acc_sum;
        step_d = step_q + STEPW'(1);
        if (step_q == LAST_STEP) begin
          // All result fields update together so the consumer sees one word.
          step_d      = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_data_d  = acc_sum[DW-1:0];
          out_range_d = (acc_sum > AW'(MAXVAL));
          out_ft_d    = ft_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cw_q        <= '0;
      prev_q      <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      ft_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_range_q <= 1'b0;
      out_ft_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cw_q        <= cw_d;
      prev_q      <= prev_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      ft_q        <= ft_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_range_q <= out_range_d;
      out_ft_q    <= out_ft_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_range_err = out_range_q;
  assign out_ft_err    = out_ft_q;

endmodule
